// File: rtl/key_debouncer_if.sv
// Key/strobe bundle between a board key pin driver and the debouncer.
// The master drives the raw key level and the slave returns the press strobe.
interface key_debouncer_if;
   logic key_i;
   logic key_pressed_stb_o;

   modport master (
      output key_i,
      input  key_pressed_stb_o
   );

   modport slave (
      input  key_i,
      output key_pressed_stb_o
   );
endinterface : key_debouncer_if

// File: rtl/key_debouncer.sv
// Push-button debouncer: synchronises an active-low key and emits one strobe per
// press that has stayed stable for the glitch time. Release is filtered identically.
module key_debouncer #(
   parameter int CLK_FREQ_MHZ   = 100,
   parameter int GLITCH_TIME_NS = 150
) (
   input  logic             clk_i,
   input  logic             srst_i,
   key_debouncer_if.slave   bus
);

   localparam int GLITCH_RAW         = (CLK_FREQ_MHZ * GLITCH_TIME_NS + 999) / 1000;
   localparam int GLITCH_TIME_CYCLES = (GLITCH_RAW < 1) ? 1 : GLITCH_RAW;
   localparam int CNT_W              = $clog2(GLITCH_TIME_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_TIME_CYCLES - 1);

   typedef enum logic {
      KEY_PRESSED  = 1'b0,
      KEY_RELEASED = 1'b1
   } key_state_e;

   logic             sync_meta_r;
   logic             sync_s_r;
   key_state_e       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             stb_r;

   key_state_e       state_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             stb_nxt_s;

   // Filter: accept the synchronised level once it has differed for the full glitch time.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = CNT_ZERO;
      stb_nxt_s   = 1'b0;
      if (sync_s_r == state_r) begin
         cnt_nxt_s = CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
         state_nxt_s = key_state_e'(sync_s_r);
         cnt_nxt_s   = CNT_ZERO;
         // Only the released-to-pressed transition produces an event.
         stb_nxt_s   = ~sync_s_r;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // Synchroniser, debounced state, counter and strobe registers; reset idles as released.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sync_meta_r <= 1'b1;
         sync_s_r    <= 1'b1;
         state_r     <= KEY_RELEASED;
         cnt_r       <= CNT_ZERO;
         stb_r       <= 1'b0;
      end else begin
         sync_meta_r <= bus.key_i;
         sync_s_r    <= sync_meta_r;
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         stb_r       <= stb_nxt_s;
      end
   end

   assign bus.key_pressed_stb_o = stb_r;

endmodule : key_debouncer

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer at default parameters (N = 15): a per-edge
// scoreboard of the debounce algorithm plus directed latency/count checks.
module tb_key_debouncer;

   localparam int N = 15;

   logic clk;
   logic srst;
   key_debouncer_if dbg_if ();

   key_debouncer #(
      .CLK_FREQ_MHZ   (100),
      .GLITCH_TIME_NS (150)
   ) dut (
      .clk_i  (clk),
      .srst_i (srst),
      .bus    (dbg_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks;
   int   n_errors;
   logic exp_q[$];

   // Reference model: run-length of samples differing from the accepted level.
   logic m_sync1;
   logic m_s;
   logic m_state;
   int   m_run;
   logic m_stb;

   int   edge_num;
   int   stb_count;
   int   last_stb_edge;
   int   adj_count;
   logic prev_stb;
   logic armed;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_num);
      end
   endtask

   // One clock edge: advance model, push expectation, clock DUT, pop and compare.
   task automatic step();
      logic dut_stb;
      logic exp_stb;
      if (srst) begin
         m_sync1 = 1'b1;
         m_s     = 1'b1;
         m_state = 1'b1;
         m_run   = 0;
         m_stb   = 1'b0;
         armed   = 1'b1;
      end else begin
         m_stb = 1'b0;
         if (m_s == m_state) begin
            m_run = 0;
         end else begin
            m_run = m_run + 1;
            if (m_run == N) begin
               m_run = 0;
               m_stb = m_state;
               if (m_state == 1'b0) armed = 1'b1;
               m_state = m_s;
            end
         end
         m_s     = m_sync1;
         m_sync1 = dbg_if.key_i;
      end
      exp_q.push_back(m_stb);
      @(posedge clk);
      #1;
      edge_num++;
      dut_stb = dbg_if.key_pressed_stb_o;
      exp_stb = exp_q.pop_front();
      check_eq("stb_scoreboard", int'(dut_stb), int'(exp_stb));
      if (dut_stb === 1'b1) begin
         stb_count++;
         last_stb_edge = edge_num;
         if (prev_stb === 1'b1) adj_count++;
         check_eq("press_after_release", int'(armed), 1);
         armed = 1'b0;
      end
      prev_stb = dut_stb;
   endtask

   task automatic drive(input logic level, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         dbg_if.key_i = level;
         step();
      end
   endtask

   int base;
   int cnt0;
   int sweep_total;

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      edge_num      = 0;
      stb_count     = 0;
      last_stb_edge = -1;
      adj_count     = 0;
      prev_stb      = 1'b0;
      armed         = 1'b1;
      m_sync1 = 1'b1; m_s = 1'b1; m_state = 1'b1; m_run = 0; m_stb = 1'b0;

      // Reset with key released; strobe must stay low throughout.
      srst = 1'b1;
      dbg_if.key_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("stb_in_reset", int'(dbg_if.key_pressed_stb_o), 0);
      end
      srst = 1'b0;

      // Clean press: one strobe, 17 edges after the fall.
      drive(1'b1, 20);
      base = edge_num;
      cnt0 = stb_count;
      drive(1'b0, 20);
      check_eq("clean_press_count", stb_count - cnt0, 1);
      check_eq("clean_press_latency", last_stb_edge - base, N + 2);

      // Short release glitch while pressed: no strobe.
      cnt0 = stb_count;
      drive(1'b1, 7);
      drive(1'b0, 100);
      drive(1'b1, 1);
      drive(1'b0, 30);
      check_eq("glitch_no_strobe", stb_count - cnt0, 0);

      // Bounce, real release, then press.
      cnt0 = stb_count;
      drive(1'b1, 5);
      drive(1'b0, 5);
      drive(1'b1, 100);
      check_eq("bounce_no_strobe", stb_count - cnt0, 0);
      base = edge_num;
      drive(1'b0, 30);
      check_eq("bounce_press_count", stb_count - cnt0, 1);
      check_eq("bounce_press_latency", last_stb_edge - base, N + 2);

      // Filter boundary sweep from released.
      drive(1'b1, 30);
      sweep_total = 0;
      for (int l = 1; l <= 30; l++) begin
         cnt0 = stb_count;
         drive(1'b0, l);
         drive(1'b1, 30);
         check_eq($sformatf("sweep_L%0d", l), stb_count - cnt0, (l >= N) ? 1 : 0);
         sweep_total += stb_count - cnt0;
      end
      check_eq("sweep_total", sweep_total, 16);

      // Reset mid-count with key held low.
      cnt0 = stb_count;
      drive(1'b0, 10);
      srst = 1'b1;
      step();
      check_eq("stb_after_srst", int'(dbg_if.key_pressed_stb_o), 0);
      srst = 1'b0;
      base = edge_num;
      drive(1'b0, 30);
      check_eq("srst_press_count", stb_count - cnt0, 1);
      check_eq("srst_press_latency", last_stb_edge - base, N + 2);

      // Random bounce against the scoreboard.
      drive(1'b1, 30);
      for (int k = 0; k < 500; k++) begin
         drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 100)));
      end
      drive(1'b1, 40);
      check_eq("adjacent_strobes", adj_count, 0);
      check_eq("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_key_debouncer
